// File: rtl/rv_mem_pkg.sv
// Shared types for the data-memory arbiter slice.
//   arb_state_t : arbiter ownership state
//   owner_t     : tag naming which requester a pending load return belongs to
package rv_mem_pkg;

  typedef enum logic {
    ARB     = 1'b0,
    EXT_OWN = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_rsp_router.sv
// Load-return router. Remembers which requester issued the load that the
// memory is answering this cycle and steers mem_rdata to that requester only.
// Ports:
//   clk, rst              clock, async active-low reset
//   load_core, load_ext   a load was granted to core / ext this cycle
//   mem_rdata             memory read data (valid the cycle after the load)
//   core_rvalid/rdata     core return pulse and data (rdata 0 when not valid)
//   ext_rvalid/rdata      ext return pulse and data (rdata 0 when not valid)
module dmem_rsp_router
  import rv_mem_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_core,
  input  logic          load_ext,
  input  logic [DW-1:0] mem_rdata,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata
);

  logic   pending;
  owner_t owner;

  // Reset drops any in-flight return; the memory answer is simply ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      owner   <= OWN_NONE;
    end else begin
      pending <= load_core | load_ext;
      if (load_core)     owner <= OWN_CORE;
      else if (load_ext) owner <= OWN_EXT;
      else               owner <= OWN_NONE;
    end
  end

  assign core_rvalid = pending & (owner == OWN_CORE);
  assign ext_rvalid  = pending & (owner == OWN_EXT);
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign ext_rdata   = ext_rvalid  ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline memory stage (core)
// and an external loader/debug master (ext). Core has fixed priority unless
// ext has been denied STARVE_MAX consecutive cycles; a granted ext access
// without ext_last may keep the memory for up to BURST_MAX beats.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ARB     | core priority, ext served when core idle or ext starved
//   EXT_OWN | ext holds the memory for the rest of its burst
//
// Ports:
//   clk, rst                                  clock, async active-low reset
//   core_req/we/addr/wdata                    core request fields
//   core_gnt, core_stall                      core accepted / core held off
//   core_rvalid, core_rdata                   core load return
//   ext_req/we/addr/wdata, ext_last           ext request fields, burst end
//   ext_gnt, ext_rvalid, ext_rdata            ext accept and load return
//   mem_en/we/addr/wdata, mem_rdata           memory side
module dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int BURST_MAX  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [DW-1:0] core_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  input  logic          ext_last,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  arb_state_t    state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          core_win, ext_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      starve_cnt <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // burst_cnt counts beats already granted in the current held burst.
  always_comb begin
    core_win  = 1'b0;
    ext_win   = 1'b0;
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      ARB: begin
        if (core_req && (starve_cnt != STARVE_TOP)) begin
          core_win = 1'b1;
        end else if (ext_req) begin
          ext_win = 1'b1;
          if (!ext_last && (BURST_MAX > 1)) begin
            state_nxt = EXT_OWN;
            burst_nxt = BW'(1);
          end
        end
      end
      EXT_OWN: begin
        if (ext_req) begin
          ext_win = 1'b1;
          if (ext_last || (burst_cnt == BURST_LAST)) begin
            state_nxt = ARB;
            burst_nxt = '0;
          end else begin
            burst_nxt = burst_cnt + 1'b1;
          end
        end else begin
          // Ext paused mid-burst: give the memory back rather than idle it.
          state_nxt = ARB;
          burst_nxt = '0;
        end
      end
      default: begin
        state_nxt = ARB;
        burst_nxt = '0;
      end
    endcase
  end

  // Grants are combinational from req, so they are gated by rst to keep
  // every output quiet for the whole reset, not just after the next edge.
  assign core_gnt   = rst & core_win;
  assign ext_gnt    = rst & ext_win;
  assign core_stall = rst & core_req & ~core_win;

  always_comb begin
    starve_nxt = starve_cnt;
    if (ext_win)
      starve_nxt = '0;
    else if (ext_req && (starve_cnt != STARVE_TOP))
      starve_nxt = starve_cnt + 1'b1;
  end

  always_comb begin
    mem_en    = core_gnt | ext_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (ext_gnt) begin
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  dmem_rsp_router #(
    .DW (DW)
  ) u_rsp_router (
    .clk         (clk),
    .rst         (rst),
    .load_core   (core_gnt & ~core_we),
    .load_ext    (ext_gnt & ~ext_we),
    .mem_rdata   (mem_rdata),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .ext_rvalid  (ext_rvalid),
    .ext_rdata   (ext_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;
  localparam int BURST_MAX  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_req, core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic          core_gnt, core_stall, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          ext_req, ext_we, ext_last;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_gnt, ext_rvalid;
  logic [DW-1:0] ext_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          own;   // 1 = core, 2 = ext
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t q[$];

  dmem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_last(ext_last), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural SRAM driven by the DUT's memory port; idle cycles return junk.
  logic [31:0] sram[logic [31:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : fill(mem_addr);
    else                   mem_rdata <= $urandom;
  end

  // Reference model: per-cycle arbitration rules on plain integers, with its
  // own copy of memory contents built from the expected grants.
  logic [31:0] ref_mem[logic [31:0]];
  int m_own = 0, m_beats = 0, m_starve = 0;

  initial forever begin
    bit e_c, e_e;
    logic        x_we;
    logic [31:0] x_addr, x_wd;
    @(negedge clk);
    if (!rst) begin
      m_own = 0; m_beats = 0; m_starve = 0;
    end else begin
      e_c = 0; e_e = 0;
      if (m_own == 0) begin
        if (core_req && m_starve < STARVE_MAX) e_c = 1;
        else if (ext_req)                      e_e = 1;
      end else begin
        e_e = ext_req;
      end
      x_we = 0; x_addr = 0; x_wd = 0;
      if (e_c)      begin x_we = core_we; x_addr = core_addr; x_wd = core_wdata; end
      else if (e_e) begin x_we = ext_we;  x_addr = ext_addr;  x_wd = ext_wdata;  end
      chk("core_gnt",   core_gnt,   e_c);
      chk("ext_gnt",    ext_gnt,    e_e);
      chk("core_stall", core_stall, core_req & !e_c);
      chk("mem_en",     mem_en,     e_c | e_e);
      chk("mem_we",     mem_we,     x_we);
      chk("mem_addr",   mem_addr,   x_addr);
      chk("mem_wdata",  mem_wdata,  x_wd);
      if (e_c || e_e) begin
        if (x_we) ref_mem[x_addr] = x_wd;
        else q.push_back('{e_c ? 1 : 2,
                           ref_mem.exists(x_addr) ? ref_mem[x_addr] : fill(x_addr),
                           cyc + 1});
      end
      if (e_e) m_starve = 0;
      else if (ext_req && m_starve < STARVE_MAX) m_starve++;
      if (m_own == 0) begin
        if (e_e) begin
          m_beats = 1;
          m_own = (!ext_last && BURST_MAX > 1) ? 1 : 0;
        end
      end else if (!ext_req) begin
        m_own = 0;
      end else begin
        m_beats++;
        if (ext_last || m_beats == BURST_MAX) m_own = 0;
      end
    end
  end

  // Monitor: consumes expected load returns whenever the DUT presents one.
  initial forever begin
    rsp_t r;
    @(negedge clk);
    if (!rst) begin
      q.delete();
    end else begin
      if (!core_rvalid) chk("core_rdata_idle", core_rdata, 0);
      if (!ext_rvalid)  chk("ext_rdata_idle",  ext_rdata,  0);
      if (core_rvalid || ext_rvalid) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          chk("unexpected_rvalid", {core_rvalid, ext_rvalid}, 0);
        end else begin
          r = q.pop_front();
          chk("rvalid_owner", {core_rvalid, ext_rvalid}, (r.own == 1) ? 2'b10 : 2'b01);
          chk("rdata", (r.own == 1) ? core_rdata : ext_rdata, r.data);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        r = q.pop_front();
        chk("missing_rvalid", 0, 1);
      end
    end
  end

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_last = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, k;
    bit ct, et;
    int e_left;
    idle();
    rst = 0;
    #1;
    core_req = 1; ext_req = 1; core_addr = 32'h100; ext_addr = 32'h104;
    #1;
    chk("rst_core_gnt",   core_gnt,   0);
    chk("rst_ext_gnt",    ext_gnt,    0);
    chk("rst_core_stall", core_stall, 0);
    chk("rst_mem_en",     mem_en,     0);
    chk("rst_mem_addr",   mem_addr,   0);
    chk("rst_rvalid",     {core_rvalid, ext_rvalid}, 0);
    idle();
    repeat (2) @(posedge clk);
    #3 rst = 1;
    next_cycle();

    // Core-only load of a preloaded word.
    core_req = 1; core_we = 0; core_addr = 32'h100;
    @(negedge clk);
    chk("core_load_gnt", core_gnt, 1);
    next_cycle();
    idle();
    @(negedge clk);
    chk("core_load_rvalid", core_rvalid, 1);
    chk("core_load_rdata",  core_rdata,  32'hDEAD_BEEF);
    chk("core_load_ext_rvalid", ext_rvalid, 0);
    next_cycle();

    // Contention: core stores every cycle, ext single-beat load waits.
    core_req = 1; core_we = 1; core_addr = 32'h200; core_wdata = 32'h1234_5678;
    ext_req = 1; ext_we = 0; ext_addr = 32'h104; ext_last = 1;
    n = 0; m = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ext_gnt) begin
        m = 1;
        chk("starve_stall", core_stall, 1);
        next_cycle();
        break;
      end
      if (core_gnt) n++;
      next_cycle();
    end
    chk("starve_core_beats", n, STARVE_MAX);
    chk("starve_ext_won", m, 1);
    idle();
    next_cycle();

    // Three-beat ext store burst with core waiting behind it.
    ext_req = 1; ext_we = 1; ext_addr = 32'h300; ext_wdata = 32'hA000_0001; ext_last = 0;
    n = 0; m = 0;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (ext_gnt) n++;
      if (core_stall) m++;
      next_cycle();
      core_req = 1; core_we = 0; core_addr = 32'h300;
      ext_addr = 32'h300 + 32'(4 * (b + 1));
      ext_wdata = 32'hA000_0002 + 32'(b);
      ext_last = (b == 1);
    end
    ext_req = 0; ext_last = 0;
    @(negedge clk);
    chk("burst3_ext_beats", n, 3);
    chk("burst3_core_stalls", m, 2);
    chk("burst3_core_after", core_gnt, 1);
    next_cycle();
    idle();
    next_cycle();

    // Burst cap: ext never signals last.
    ext_req = 1; ext_we = 1; ext_addr = 32'h340; ext_wdata = 32'hB000_0000; ext_last = 0;
    n = 0; m = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (ext_gnt) n++;
      if (core_gnt) begin m = 1; next_cycle(); break; end
      next_cycle();
      core_req = 1; core_we = 0; core_addr = 32'h344;
      ext_wdata = ext_wdata + 1;
    end
    chk("burst_cap_beats", n, BURST_MAX);
    chk("burst_cap_core_won", m, 1);
    idle();
    next_cycle();

    // Alternating core/ext loads back to back.
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i % 2 == 0) begin core_req = 1; core_addr = 32'h100 + 32'(4 * i); end
      else begin ext_req = 1; ext_last = 1; ext_addr = 32'h300 + 32'(4 * i); end
      @(negedge clk);
      if (i > 0) chk("alt_rvalid", {core_rvalid, ext_rvalid}, (i % 2 == 1) ? 2'b10 : 2'b01);
      next_cycle();
    end
    idle();
    next_cycle();

    // Reset mid-burst with a load return pending.
    ext_req = 1; ext_we = 0; ext_addr = 32'h300; ext_last = 0;
    next_cycle();
    ext_addr = 32'h304;
    next_cycle();
    core_req = 1; core_addr = 32'h100;
    #2 rst = 0;
    #1;
    chk("midrst_outputs", {core_gnt, ext_gnt, core_stall, core_rvalid, ext_rvalid, mem_en, mem_we}, 0);
    chk("midrst_data", {core_rdata, ext_rdata}, 0);
    chk("midrst_mem", {mem_addr, mem_wdata}, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    idle();
    @(negedge clk);
    chk("postrst_no_rvalid", {core_rvalid, ext_rvalid}, 0);
    next_cycle();

    // Randomised traffic; requesters hold fields until granted.
    e_left = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ct = core_gnt; et = ext_gnt;
      next_cycle();
      if (!core_req || ct) begin
        if ($urandom_range(0, 9) < 6) begin
          core_req = 1; core_we = 1'($urandom_range(0, 1));
          core_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
          core_wdata = $urandom;
        end else core_req = 0;
      end
      if (!ext_req || et) begin
        if (e_left > 0 && $urandom_range(0, 9) != 0) begin
          e_left--; ext_req = 1;
          ext_addr = ext_addr + 4; ext_wdata = $urandom;
          ext_last = (e_left == 0);
        end else if (e_left == 0 && $urandom_range(0, 9) < 3) begin
          k = $urandom_range(1, 10);
          e_left = k - 1; ext_req = 1;
          ext_we = 1'($urandom_range(0, 1));
          ext_addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
          ext_wdata = $urandom;
          ext_last = (e_left == 0);
        end else begin
          ext_req = 0;
        end
      end
    end
    idle();
    repeat (4) next_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
